// File: rtl/apb_multi_slave_responder.sv
// Bank of independent APB4 slaves, each with its own word memory, programmable
// wait states, address-range error response and sticky protocol-violation flag.
module apb_multi_slave_responder #(
   parameter int NO_OF_SLAVES  = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 16,
   parameter int MEM_DEPTH     = 256,
   parameter int WAIT_WIDTH    = 4
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NO_OF_SLAVES-1:0]            PSELx,
   input  logic                               PENABLE,
   input  logic                               PWRITE,
   input  logic [ADDRESS_WIDTH-1:0]           PADDR,
   input  logic [DATA_WIDTH-1:0]              PWDATA,
   input  logic [DATA_WIDTH/8-1:0]            PSTRB,
   input  logic [NO_OF_SLAVES*WAIT_WIDTH-1:0] cfg_wait,
   output logic [NO_OF_SLAVES*DATA_WIDTH-1:0] PRDATA,
   output logic [NO_OF_SLAVES-1:0]            PREADY,
   output logic [NO_OF_SLAVES-1:0]            PSLVERR,
   output logic [NO_OF_SLAVES-1:0]            proto_err
);

   // state  | meaning
   // IDLE   | no transfer; waiting for a setup phase
   // ACCESS | setup latched; counting wait states, PREADY when counter is 0
   typedef enum logic {IDLE, ACCESS} state_t;

   localparam int SW    = DATA_WIDTH / 8;
   localparam int SHIFT = $clog2(SW);
   localparam int IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH+1)'(MEM_DEPTH);

   genvar i;
   for (i = 0; i < NO_OF_SLAVES; i++) begin : g_slave
      state_t                   state;
      logic [WAIT_WIDTH-1:0]    cnt;
      logic                     write_q;
      logic [ADDRESS_WIDTH-1:0] addr_q;
      logic [DATA_WIDTH-1:0]    wdata_q;
      logic [SW-1:0]            strb_q;
      logic                     perr;
      logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

      logic [ADDRESS_WIDTH-1:0] idx;
      logic [IW-1:0]            widx;
      logic                     addr_err;
      logic                     ready;

      assign idx      = addr_q >> SHIFT;
      assign widx     = idx[IW-1:0];
      assign addr_err = {1'b0, idx} >= DEPTH_L;
      assign ready    = (state == ACCESS) && (cnt == '0);

      assign PREADY[i]    = ready;
      assign PSLVERR[i]   = ready && addr_err;
      assign proto_err[i] = perr;
      assign PRDATA[i*DATA_WIDTH +: DATA_WIDTH] =
         (ready && !write_q && !addr_err) ? mem[widx] : '0;

      always_ff @(posedge clock) begin
         if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            perr    <= 1'b0;
            for (int k = 0; k < MEM_DEPTH; k++) mem[k] <= '0;
         end else if (PSELx[i] && !PENABLE) begin
            // A setup phase always restarts the transfer, even mid-ACCESS.
            state   <= ACCESS;
            cnt     <= cfg_wait[i*WAIT_WIDTH +: WAIT_WIDTH];
            write_q <= PWRITE;
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            if (state == ACCESS) perr <= 1'b1;
         end else if (state == ACCESS) begin
            if (!PSELx[i]) begin
               state <= IDLE;
               cnt   <= '0;
               perr  <= 1'b1;
            end else if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else begin
               state <= IDLE;
               if (write_q && !addr_err) begin
                  for (int b = 0; b < SW; b++)
                     if (strb_q[b]) mem[widx][b*8 +: 8] <= wdata_q[b*8 +: 8];
               end
            end
         end else if (PSELx[i] && PENABLE) begin
            perr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_multi_slave_responder.sv
// Directed bench for apb_multi_slave_responder: transfers, wait states, strobes,
// address errors, protocol violations and mid-transfer reset.
module tb_apb_multi_slave_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  PSELx;
   logic        PENABLE;
   logic        PWRITE;
   logic [15:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [15:0] cfg_wait;
   logic [127:0] PRDATA;
   logic [3:0]  PREADY;
   logic [3:0]  PSLVERR;
   logic [3:0]  proto_err;

   int total = 0;
   int bad   = 0;

   apb_multi_slave_responder dut (
      .clock(clock), .reset(reset), .PSELx(PSELx), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .cfg_wait(cfg_wait), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .proto_err(proto_err)
   );

   always #5 clock = ~clock;

   task automatic bus_idle();
      @(negedge clock);
      PSELx = '0; PENABLE = 1'b0;
   endtask

   // Setup + access phases; returns sampled data/error in the PREADY cycle.
   task automatic apb_xfer(input int s, input logic w, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] st,
                           output logic [31:0] rd, output logic rdy,
                           output logic err, output int waits);
      @(negedge clock);
      PSELx = '0; PSELx[s] = 1'b1; PENABLE = 1'b0;
      PWRITE = w; PADDR = a; PWDATA = d; PSTRB = st;
      @(negedge clock);
      PENABLE = 1'b1;
      waits = 0;
      while (!PREADY[s] && waits < 20) begin
         @(negedge clock);
         waits++;
      end
      rdy = PREADY[s];
      err = PSLVERR[s];
      rd  = PRDATA[s*32 +: 32];
   endtask

   task automatic test_reset();
      total++; if (PREADY !== 4'h0)    begin bad++; $display("FAIL reset_pready got=%h exp=0", PREADY); end
      total++; if (PSLVERR !== 4'h0)   begin bad++; $display("FAIL reset_pslverr got=%h exp=0", PSLVERR); end
      total++; if (proto_err !== 4'h0) begin bad++; $display("FAIL reset_proto got=%h exp=0", proto_err); end
      total++; if (PRDATA !== '0)      begin bad++; $display("FAIL reset_prdata got=%h exp=0", PRDATA); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] rd; logic rdy, err; int w;
      apb_xfer(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, rd, rdy, err, w);
      bus_idle();
      total++; if (rdy !== 1'b1 || w != 0) begin bad++; $display("FAIL zw_write_ready got rdy=%b waits=%0d exp 1/0", rdy, w); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL zw_write_err got=%b exp=0", err); end
      apb_xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, rd, rdy, err, w);
      total++; if (w != 0) begin bad++; $display("FAIL zw_read_waits got=%0d exp=0", w); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL zw_read_data got=%h exp=deadbeef", rd); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL zw_read_err got=%b exp=0", err); end
      bus_idle();
      #1;
      total++; if (PRDATA[31:0] !== 32'h0) begin bad++; $display("FAIL zw_prdata_idle got=%h exp=0", PRDATA[31:0]); end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; logic rdy, err; int w;
      cfg_wait[11:8] = 4'd3;
      apb_xfer(2, 1'b0, 16'h0000, 32'h0, 4'h0, rd, rdy, err, w);
      bus_idle();
      total++; if (rdy !== 1'b1 || w != 3) begin bad++; $display("FAIL ws_waits got rdy=%b waits=%0d exp 1/3", rdy, w); end
      total++; if (rd !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL ws_data got=%h err=%b exp 0/0", rd, err); end
      cfg_wait[11:8] = 4'd0;
   endtask

   task automatic test_strobe();
      logic [31:0] rd; logic rdy, err; int w;
      apb_xfer(1, 1'b1, 16'h0004, 32'h11223344, 4'hF, rd, rdy, err, w);
      apb_xfer(1, 1'b1, 16'h0004, 32'hAABBCCDD, 4'h5, rd, rdy, err, w);
      apb_xfer(1, 1'b0, 16'h0004, 32'h0, 4'h0, rd, rdy, err, w);
      bus_idle();
      total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_data got=%h exp=11bb33dd", rd); end
   endtask

   task automatic test_addr_err();
      logic [31:0] rd; logic rdy, err; int w;
      apb_xfer(3, 1'b1, 16'h0400, 32'hFFFFFFFF, 4'hF, rd, rdy, err, w);
      bus_idle();
      total++; if (rdy !== 1'b1 || err !== 1'b1 || w != 0) begin bad++; $display("FAIL aerr_write got rdy=%b err=%b waits=%0d exp 1/1/0", rdy, err, w); end
      apb_xfer(3, 1'b0, 16'h0400, 32'h0, 4'h0, rd, rdy, err, w);
      bus_idle();
      total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL aerr_read got err=%b data=%h exp 1/0", err, rd); end
      apb_xfer(3, 1'b1, 16'h03FC, 32'hCAFEF00D, 4'hF, rd, rdy, err, w);
      apb_xfer(3, 1'b0, 16'h03FC, 32'h0, 4'h0, rd, rdy, err, w);
      bus_idle();
      total++; if (err !== 1'b0 || rd !== 32'hCAFEF00D) begin bad++; $display("FAIL aerr_last_word got err=%b data=%h exp 0/cafef00d", err, rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic rdy, err; int w;
      apb_xfer(0, 1'b1, 16'h0020, 32'h01020304, 4'hF, rd, rdy, err, w);
      apb_xfer(0, 1'b0, 16'h0020, 32'h0, 4'h0, rd, rdy, err, w);
      bus_idle();
      total++; if (rd !== 32'h01020304 || w != 0) begin bad++; $display("FAIL b2b_read got=%h waits=%0d exp 01020304/0", rd, w); end
      total++; if (proto_err[0] !== 1'b0) begin bad++; $display("FAIL b2b_proto got=%b exp=0", proto_err[0]); end
   endtask

   task automatic test_proto();
      logic [31:0] rd; logic rdy, err; int w;
      apb_xfer(0, 1'b1, 16'h0030, 32'h55AA55AA, 4'hF, rd, rdy, err, w);
      bus_idle();
      cfg_wait[3:0] = 4'd2;
      @(negedge clock);
      PSELx = 4'b0001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0030; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
      @(negedge clock);
      PENABLE = 1'b1;
      @(negedge clock);
      PSELx = 4'b0000;
      @(negedge clock);
      PENABLE = 1'b0;
      total++; if (proto_err[0] !== 1'b1 || PREADY[0] !== 1'b0) begin bad++; $display("FAIL drop_psel got proto=%b ready=%b exp 1/0", proto_err[0], PREADY[0]); end
      cfg_wait[3:0] = 4'd0;
      apb_xfer(0, 1'b0, 16'h0030, 32'h0, 4'h0, rd, rdy, err, w);
      bus_idle();
      total++; if (rd !== 32'h55AA55AA) begin bad++; $display("FAIL drop_word got=%h exp=55aa55aa", rd); end
      // IDLE with PSEL&PENABLE on slave 2
      @(negedge clock);
      PSELx = 4'b0100; PENABLE = 1'b1;
      bus_idle();
      total++; if (proto_err !== 4'b0101) begin bad++; $display("FAIL idle_enable got=%b exp=0101", proto_err); end
      // fresh setup while slave 3 is mid-ACCESS
      cfg_wait[15:12] = 4'd2;
      @(negedge clock);
      PSELx = 4'b1000; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0010; PWDATA = 32'hAAAA0001; PSTRB = 4'hF;
      @(negedge clock);
      PENABLE = 1'b1;
      apb_xfer(3, 1'b1, 16'h0010, 32'hBBBB0002, 4'hF, rd, rdy, err, w);
      total++; if (w != 2 || rdy !== 1'b1) begin bad++; $display("FAIL resetup_waits got=%0d rdy=%b exp 2/1", w, rdy); end
      cfg_wait[15:12] = 4'd0;
      apb_xfer(3, 1'b0, 16'h0010, 32'h0, 4'h0, rd, rdy, err, w);
      bus_idle();
      total++; if (rd !== 32'hBBBB0002 || proto_err[3] !== 1'b1) begin bad++; $display("FAIL resetup got data=%h proto=%b exp bbbb0002/1", rd, proto_err[3]); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic rdy, err; int w;
      cfg_wait[7:4] = 4'd3;
      @(negedge clock);
      PSELx = 4'b0010; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0008; PWDATA = 32'h12345678; PSTRB = 4'hF;
      @(negedge clock);
      PENABLE = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; PSELx = '0; PENABLE = 1'b0;
      total++; if (PREADY !== 4'h0 || PSLVERR !== 4'h0) begin bad++; $display("FAIL rst_mid_ready got=%b/%b exp 0/0", PREADY, PSLVERR); end
      total++; if (proto_err !== 4'h0 || PRDATA !== '0) begin bad++; $display("FAIL rst_mid_flags got proto=%b data=%h exp 0/0", proto_err, PRDATA); end
      cfg_wait[7:4] = 4'd0;
      apb_xfer(1, 1'b0, 16'h0004, 32'h0, 4'h0, rd, rdy, err, w);
      bus_idle();
      total++; if (rd !== 32'h0 || rdy !== 1'b1) begin bad++; $display("FAIL rst_mid_mem got=%h rdy=%b exp 0/1", rd, rdy); end
   endtask

   initial begin
      reset = 1'b1; PSELx = '0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; PSTRB = '0; cfg_wait = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_strobe();
      test_addr_err();
      test_back_to_back();
      test_proto();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
